io_register_file: RTL
=====================

IO_REGISTER_FILE -- requirements
Module: io_register_file

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8: data width of every register and port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, legal range 3..6: register address width, N = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: synchroniser depth on sw, ready_in and pattern_match.
REQ-004 SHALL have parameter OUT_ADDR, default N-1, legal range 4..N-1: GPR mirrored on out_port.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 sw  in  BUS_WIDTH  asynchronous switch input.
REQ-009 ready_in  in  1  asynchronous input-ready strobe/level.
REQ-010 pattern_match  in  1  asynchronous match indication.
REQ-011 we  in  1  write enable.
REQ-012 wr_addr  in  ADDR_WIDTH  write address.
REQ-013 wr_data  in  BUS_WIDTH  write data.
REQ-014 rd_addr_a, rd_addr_b  in  ADDR_WIDTH each  read addresses.
REQ-015 rd_data_a, rd_data_b  out  BUS_WIDTH each  combinational read data.
REQ-016 out_port  out  BUS_WIDTH  registered copy of GPR[OUT_ADDR].
REQ-017 out_valid  out  1  one-cycle pulse when out_port updates.

Function
REQ-018 Address map: 0 = constant zero; 1 = synchronised sw; 2 = {0..., ready_flag}; 3 = {0..., match_flag}; 4..N-1 = general-purpose registers (GPRs).
REQ-019 Writes with we=1 to address 4..N-1 SHALL update that GPR at the next rising edge.
REQ-020 Writes to address 0 or 1 SHALL be ignored.
REQ-021 Write to address 2 SHALL clear ready_flag; write to address 3 SHALL clear match_flag; wr_data is ignored for both.
REQ-022 sw, ready_in and pattern_match SHALL each pass through a SYNC_STAGES-deep flop chain before any use.
REQ-023 ready_flag SHALL set on a synchronised 0->1 transition of ready_in and hold (sticky) until cleared by REQ-021; match_flag likewise from pattern_match.
REQ-024 A flag SHALL read as 1 on the read ports starting SYNC_STAGES+1 rising edges after its input is first sampled high.
REQ-025 A level held high SHALL set a flag only once; a new rising edge is required to set it again after clearing.
REQ-026 When a set and a clear of the same flag occur at the same edge, set SHALL win.
REQ-027 Reads SHALL be combinational from rd_addr_* with no added latency.
REQ-028 With BYPASS=1, we=1, and wr_addr == rd_addr_x in 4..N-1, rd_data_x SHALL equal wr_data in the same cycle.
REQ-029 With BYPASS=0, the condition in REQ-028 SHALL return the old GPR value.
REQ-030 Forwarding SHALL never apply to addresses 0..3.
REQ-031 Both read ports SHALL operate independently and may address the same location simultaneously.
REQ-032 On a write to OUT_ADDR, out_port SHALL take wr_data at that edge, and out_valid SHALL be 1 for exactly the following cycle.
REQ-033 Back-to-back writes to OUT_ADDR SHALL hold out_valid high for consecutive cycles, one per write.

Reset
REQ-034 While rst=1, all GPRs, both flags, all synchroniser flops and edge-detect flops SHALL be 0.
REQ-035 While rst=1, out_port SHALL be 0 and out_valid SHALL be 0, independent of clk.
REQ-036 Writes presented while rst=1 SHALL be discarded.
REQ-037 Reset asserted mid-synchronisation SHALL discard any pending flag set.
REQ-038 The first write after rst deasserts SHALL take effect at the first rising edge with rst=0.

Verification
REQ-039 Reset: write 8'hA5 to addr 5, then pulse rst between edges -> rd_data_a(5)=0 and out_port=0 immediately, without waiting for an edge.
REQ-040 Map: sw=8'h3C held 3 cycles, read addr 1 on port a and addr 0 on port b -> rd_data_a=8'h3C, rd_data_b=0; write 8'hFF to addr 0 and re-read -> rd_data_b still 0.
REQ-041 Sticky flag: ready_in high for 1 cycle -> addr 2 reads 1 from edge 3 (SYNC_STAGES=2) and stays 1 for 10 cycles; write addr 2 -> reads 0 next cycle; with ready_in held high, flag does not re-set.
REQ-042 Set/clear collision: write addr 3 at the same edge a match rising edge is detected -> match_flag reads 1.
REQ-043 Bypass: BYPASS=1, we=1, wr_addr=6, wr_data=8'h5A, rd_addr_a=6 with GPR6=8'h11 -> rd_data_a=8'h5A that cycle; BYPASS=0 -> 8'h11 that cycle, 8'h5A next.
REQ-044 Output: writes of 8'h01 and 8'h02 to addr 7 on consecutive edges -> out_port 8'h01 then 8'h02, out_valid high for 2 cycles then 0; write to addr 6 -> out_valid stays 0.

Source files
------------

// File: rtl/io_register_file.sv
// ----------------------------------------------------------------------------
// io_register_file
//
// Small memory-mapped register file bridging asynchronous board I/O to a
// synchronous core. There are two combinational read ports and one write port.
//
// Address map
//   0         constant zero (writes ignored)
//   1         synchronised sw (writes ignored)
//   2         {0..., ready_flag}  sticky, set on ready_in rising edge,
//             cleared by any write to this address
//   3         {0..., match_flag}  same behaviour, driven by pattern_match
//   4..N-1    general-purpose registers (GPRs)
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   sw             asynchronous switch bus
//   ready_in       asynchronous ready strobe/level
//   pattern_match  asynchronous match indication
//   we/wr_addr/wr_data         write port
//   rd_addr_a/b -> rd_data_a/b combinational read ports
//   out_port       registered mirror of GPR[OUT_ADDR]
//   out_valid      one-cycle pulse following each write to OUT_ADDR
// ----------------------------------------------------------------------------
module io_register_file #(
  parameter int BUS_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_ADDR    = (1 << ADDR_WIDTH) - 1,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  sw,
  input  logic                  ready_in,
  input  logic                  pattern_match,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [BUS_WIDTH-1:0]  rd_data_a,
  output logic [BUS_WIDTH-1:0]  rd_data_b,
  output logic [BUS_WIDTH-1:0]  out_port,
  output logic                  out_valid
);

  localparam int N = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SW    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_READY = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MATCH = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT   = ADDR_WIDTH'(OUT_ADDR);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic [BUS_WIDTH-1:0]   sw_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ready_sync_q;
  logic [SYNC_STAGES-1:0] match_sync_q;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sw_sync_q[gi]    <= '0;
            ready_sync_q[gi] <= 1'b0;
            match_sync_q[gi] <= 1'b0;
          end else begin
            sw_sync_q[gi]    <= sw;
            ready_sync_q[gi] <= ready_in;
            match_sync_q[gi] <= pattern_match;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sw_sync_q[gi]    <= '0;
            ready_sync_q[gi] <= 1'b0;
            match_sync_q[gi] <= 1'b0;
          end else begin
            sw_sync_q[gi]    <= sw_sync_q[gi-1];
            ready_sync_q[gi] <= ready_sync_q[gi-1];
            match_sync_q[gi] <= match_sync_q[gi-1];
          end
        end
      end
    end
  endgenerate

  logic [BUS_WIDTH-1:0] sw_s;
  logic                 ready_s;
  logic                 match_s;

  assign sw_s    = sw_sync_q[SYNC_STAGES-1];
  assign ready_s = ready_sync_q[SYNC_STAGES-1];
  assign match_s = match_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Edge detection and sticky flags
  // --------------------------------------------------------------------------
  logic ready_prev_q, match_prev_q;
  logic ready_flag_q, ready_flag_d;
  logic match_flag_q, match_flag_d;
  logic ready_rise, match_rise;
  logic ready_clr, match_clr;

  assign ready_rise = ready_s & ~ready_prev_q;
  assign match_rise = match_s & ~match_prev_q;
  assign ready_clr  = we && (wr_addr == ADDR_READY);
  assign match_clr  = we && (wr_addr == ADDR_MATCH);

  // A rise detected on the same edge as a clear wins, so no event is lost.
  assign ready_flag_d = ready_rise | (ready_flag_q & ~ready_clr);
  assign match_flag_d = match_rise | (match_flag_q & ~match_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_prev_q <= 1'b0;
      match_prev_q <= 1'b0;
      ready_flag_q <= 1'b0;
      match_flag_q <= 1'b0;
    end else begin
      ready_prev_q <= ready_s;
      match_prev_q <= match_s;
      ready_flag_q <= ready_flag_d;
      match_flag_q <= match_flag_d;
    end
  end

  // --------------------------------------------------------------------------
  // General-purpose registers. Entries 0..3 exist only so the array can be
  // indexed directly by a full-width address; they are held at zero and are
  // never selected by the read mux.
  // --------------------------------------------------------------------------
  logic [BUS_WIDTH-1:0] gpr_q [N];

  generate
    for (gi = 0; gi < N; gi++) begin : g_gpr
      if (gi >= 4) begin : g_rw
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            gpr_q[gi] <= '0;
          end else if (we && (wr_addr == ADDR_WIDTH'(gi))) begin
            gpr_q[gi] <= wr_data;
          end
        end
      end else begin : g_fixed
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            gpr_q[gi] <= '0;
          end else begin
            gpr_q[gi] <= '0;
          end
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output mirror
  // --------------------------------------------------------------------------
  logic                 out_wr;
  logic [BUS_WIDTH-1:0] out_port_q;
  logic                 out_valid_q;

  assign out_wr = we && (wr_addr == ADDR_OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_wr;
      if (out_wr) begin
        out_port_q <= wr_data;
      end
    end
  end

  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;

  // --------------------------------------------------------------------------
  // Read ports (identical, independent)
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_addr_arr [2];
  logic [BUS_WIDTH-1:0]  rd_data_arr [2];

  assign rd_addr_arr[0] = rd_addr_a;
  assign rd_addr_arr[1] = rd_addr_b;
  assign rd_data_a      = rd_data_arr[0];
  assign rd_data_b      = rd_data_arr[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Forwarding is suppressed during reset because such writes are
      // discarded; the default branch below only covers GPR addresses, so
      // addresses 0..3 are never forwarded.
      logic fwd;
      assign fwd = BYPASS && we && !rst && (wr_addr == rd_addr_arr[gi]);

      always_comb begin
        rd_data_arr[gi] = '0;
        case (rd_addr_arr[gi])
          ADDR_ZERO:  rd_data_arr[gi] = '0;
          ADDR_SW:    rd_data_arr[gi] = sw_s;
          ADDR_READY: rd_data_arr[gi] = {{(BUS_WIDTH-1){1'b0}}, ready_flag_q};
          ADDR_MATCH: rd_data_arr[gi] = {{(BUS_WIDTH-1){1'b0}}, match_flag_q};
          default: begin
            if (fwd) begin
              rd_data_arr[gi] = wr_data;
            end else begin
              rd_data_arr[gi] = gpr_q[rd_addr_arr[gi]];
            end
          end
        endcase
      end
    end
  endgenerate

endmodule
